multicycle_cla_subtractor: RTL

//  Sequential WIDTH-bit subtractor, the inverse operation of the 4-bit carry_look_ahead_adder.

---
 rtl/cla_pkg.sv | 16 +
 rtl/carry_look_ahead_adder.sv | 29 ++
 rtl/multicycle_cla_subtractor.sv | 107 ++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants for the chunked CLA subtractor: the slice width and the FSM state encoding.
package cla_pkg;

    localparam int CHUNK = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/carry_look_ahead_adder.sv
// 4-bit carry-look-ahead adder slice: all carries are formed from generate/propagate terms in parallel.
module carry_look_ahead_adder (
    input  logic [3:0] InputA,
    input  logic [3:0] InputB,
    input  logic       InputCarry,
    output logic [3:0] SumOut,
    output logic       CarryOut
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = InputA ^ InputB;
    assign w_g = InputA & InputB;

    assign w_c[0] = InputCarry;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign SumOut   = w_p ^ w_c[3:0];
    assign CarryOut = w_c[4];

endmodule

// File: rtl/multicycle_cla_subtractor.sv
// Sequential WIDTH-bit subtractor: A - B - Bin computed as A + ~B + ~Bin, one 4-bit chunk per cycle,
// LSB first, with the chunk carry held in a register between cycles.
module multicycle_cla_subtractor
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic             InputBorrow,
    output logic [WIDTH-1:0] DiffOut,
    output logic             BorrowOut,
    output logic             Overflow,
    output logic             done
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_c;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_ovf;
    logic               r_done;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_nb_chunk;
    logic [CHUNK-1:0]   w_sum;
    logic               w_cout;
    logic               w_last;

    assign w_a_chunk  = r_a[r_idx*CHUNK +: CHUNK];
    assign w_nb_chunk = ~r_b[r_idx*CHUNK +: CHUNK];
    assign w_last     = (r_idx == IDX_W'(N - 1));

    carry_look_ahead_adder u_slice (
        .InputA     (w_a_chunk),
        .InputB     (w_nb_chunk),
        .InputCarry (r_c),
        .SumOut     (w_sum),
        .CarryOut   (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= InputA;
                        r_b      <= InputB;
                        r_c      <= ~InputBorrow;
                        r_idx    <= '0;
                        r_diff   <= '0;
                        r_borrow <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_diff[r_idx*CHUNK +: CHUNK] <= w_sum;
                    r_c <= w_cout;
                    if (w_last) begin
                        // The top chunk's sum bit is the final result MSB, so the flags settle here.
                        r_borrow <= ~w_cout;
                        r_ovf    <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sum[CHUNK-1] != r_a[WIDTH-1]);
                        r_done   <= 1'b1;
                        r_idx    <= '0;
                        r_state  <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (r_state == IDLE);
    assign DiffOut   = r_diff;
    assign BorrowOut = r_borrow;
    assign Overflow  = r_ovf;
    assign done      = r_done;

endmodule
